// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame packer.
// Optional trailer word is compiled in with ADC_FRAME_PACKER_TRAILER_EN.
package adc_frame_pkg;

   localparam int SAMPLE_W    = 14;
   localparam int WORD_W      = 16;
   localparam int FRAME_CNT_W = 12;

   localparam logic [1:0] TAG_HDR  = 2'b10;
   localparam logic [1:0] TAG_DATA = 2'b00;
   localparam logic [1:0] TAG_TRL  = 2'b11;

`ifdef ADC_FRAME_PACKER_TRAILER_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_TRAILER = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;
`endif

   function automatic logic [WORD_W-1:0] hdr_word(input logic [1:0] ch,
                                                  input logic [FRAME_CNT_W-1:0] cnt);
      return {TAG_HDR, ch, cnt};
   endfunction

   function automatic logic [WORD_W-1:0] data_word(input logic [SAMPLE_W-1:0] s);
      return {TAG_DATA, s};
   endfunction

   function automatic logic [WORD_W-1:0] trl_word(input logic [7:0] lost);
      return {TAG_TRL, 6'b0, lost};
   endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// Word buffer between the packer FSM and the SRAM FIFO write port.
// First-word-fall-through: rdata shows the head whenever not empty.
// Full/empty come from registered occupancy, so a same-cycle pop never
// makes room for a same-cycle push.
module adc_frame_fifo
   import adc_frame_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [WORD_W-1:0] wdata,
   input  logic              pop,
   output logic [WORD_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointer and occupancy values
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; reset discards buffered words
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/adc_frame_packer.sv
// ADC frame packer: captures CONF_SAMPLES samples after START and emits
// header/data(/trailer) words into a small buffer drained to the SRAM FIFO.
// Trailer word is present only when ADC_FRAME_PACKER_TRAILER_EN is defined.
// Push is always gated by the buffer's registered full flag; drain is
// FIFO_WRITE = !empty & !FIFO_FULL with the pop taken the same cycle.
module adc_frame_packer
   import adc_frame_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                ADC_CLK,
   input  logic                ADC_RST,
   input  logic [SAMPLE_W-1:0] ADC_DATA,
   input  logic                ADC_VALID,
   input  logic                START,
   input  logic [15:0]         CONF_SAMPLES,
   input  logic [1:0]          CONF_CH_ID,
   input  logic                FIFO_FULL,
   output logic [WORD_W-1:0]   FIFO_DATA,
   output logic                FIFO_WRITE,
   output logic                BUSY,
   output logic                DONE,
   output logic [7:0]          LOST_COUNT,
   output logic [1:0]          DBG_STATE
);

   state_t                 state_q, state_d;
   logic [15:0]            conf_q, conf_d;
   logic [1:0]             ch_q, ch_d;
   logic [FRAME_CNT_W-1:0] frame_q, frame_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [7:0]             lost_q, lost_d;

   logic                   push;
   logic [WORD_W-1:0]      push_word;
   logic                   done;
   logic                   buf_full, buf_empty;

   // Frame sequencing, word formatting and loss accounting
   always_comb begin
      state_d   = state_q;
      conf_d    = conf_q;
      ch_d      = ch_q;
      frame_d   = frame_q;
      cnt_d     = cnt_q;
      lost_d    = lost_q;
      push      = 1'b0;
      push_word = '0;
      done      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               conf_d  = CONF_SAMPLES;
               ch_d    = CONF_CH_ID;
               cnt_d   = '0;
               lost_d  = '0;
               state_d = ST_HEADER;
            end
         end
         ST_HEADER: begin
            if (!buf_full) begin
               push      = 1'b1;
               push_word = hdr_word(ch_q, frame_q);
               frame_d   = frame_q + 1'b1;
               if (conf_q == '0) begin
`ifdef ADC_FRAME_PACKER_TRAILER_EN
                  state_d = ST_TRAILER;
`else
                  state_d = ST_IDLE;
                  done    = 1'b1;
`endif
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
         end
         ST_CAPTURE: begin
            if (ADC_VALID) begin
               cnt_d = cnt_q + 1'b1;
               if (!buf_full) begin
                  push      = 1'b1;
                  push_word = data_word(ADC_DATA);
               end else if (lost_q != 8'hFF) begin
                  lost_d = lost_q + 1'b1;
               end
               if (cnt_d == conf_q) begin
`ifdef ADC_FRAME_PACKER_TRAILER_EN
                  state_d = ST_TRAILER;
`else
                  state_d = ST_IDLE;
                  done    = 1'b1;
`endif
               end
            end
         end
`ifdef ADC_FRAME_PACKER_TRAILER_EN
         ST_TRAILER: begin
            if (!buf_full) begin
               push      = 1'b1;
               push_word = trl_word(lost_q);
               done      = 1'b1;
               state_d   = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and frame registers
   always_ff @(posedge ADC_CLK or posedge ADC_RST) begin
      if (ADC_RST) begin
         state_q <= ST_IDLE;
         conf_q  <= '0;
         ch_q    <= '0;
         frame_q <= '0;
         cnt_q   <= '0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         conf_q  <= conf_d;
         ch_q    <= ch_d;
         frame_q <= frame_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
      end
   end

   adc_frame_fifo #(.DEPTH(DEPTH)) u_buf (
      .clk   (ADC_CLK),
      .rst   (ADC_RST),
      .push  (push),
      .wdata (push_word),
      .pop   (FIFO_WRITE),
      .rdata (FIFO_DATA),
      .full  (buf_full),
      .empty (buf_empty)
   );

   assign FIFO_WRITE = ~buf_empty & ~FIFO_FULL;
   assign BUSY       = (state_q != ST_IDLE);
   assign DONE       = done;
   assign LOST_COUNT = lost_q;
   assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed steps plus randomized frames, all
// checked cycle by cycle against a queue-based reference of the framing rules.
module tb_adc_frame_packer;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] data;
   logic        valid;
   logic        start;
   logic [15:0] conf;
   logic [1:0]  ch;
   logic        full;
   logic [15:0] FIFO_DATA;
   logic        FIFO_WRITE;
   logic        BUSY;
   logic        DONE;
   logic [7:0]  LOST_COUNT;
   logic [1:0]  DBG_STATE;

   int errors = 0;
   int checks = 0;

   // Reference model: frame phase 0=idle 1=header 2=capture 3=trailer
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          m_st, m_frame, m_cnt, m_conf, m_lost;
   logic [1:0]  m_ch;
   int          done_cnt, n_wr;

   adc_frame_packer #(.DEPTH(DEPTH)) dut (
      .ADC_CLK      (clk),
      .ADC_RST      (rst),
      .ADC_DATA     (data),
      .ADC_VALID    (valid),
      .START        (start),
      .CONF_SAMPLES (conf),
      .CONF_CH_ID   (ch),
      .FIFO_FULL    (full),
      .FIFO_DATA    (FIFO_DATA),
      .FIFO_WRITE   (FIFO_WRITE),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .LOST_COUNT   (LOST_COUNT),
      .DBG_STATE    (DBG_STATE)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_st = 0; m_frame = 0; m_cnt = 0; m_conf = 0; m_lost = 0; m_ch = 2'b00;
   endtask

   // One clock: check outputs at negedge, advance the model, move inputs after posedge
   task automatic step();
      int          occ;
      logic        e_pop, e_push, e_done;
      logic [15:0] e_word;
      @(negedge clk);
      occ    = exp_q.size();
      e_pop  = (occ > 0) && !full;
      e_push = 1'b0;
      e_done = 1'b0;
      e_word = '0;
      chk("fifo_write", 32'(FIFO_WRITE), 32'(e_pop));
      chk("fifo_data", 32'(FIFO_DATA), (occ > 0) ? 32'(exp_q[0]) : 32'h0);
      chk("busy", 32'(BUSY), 32'(m_st != 0));
      chk("lost_count", 32'(LOST_COUNT), 32'(m_lost));
      case (m_st)
         0: if (start) begin
               m_conf = int'(conf); m_ch = ch; m_cnt = 0; m_lost = 0; m_st = 1;
            end
         1: if (occ < DEPTH) begin
               e_push  = 1'b1;
               e_word  = {2'b10, m_ch, 12'(m_frame)};
               m_frame = (m_frame + 1) % 4096;
               if (m_conf == 0) begin
`ifdef ADC_FRAME_PACKER_TRAILER_EN
                  m_st = 3;
`else
                  m_st = 0; e_done = 1'b1;
`endif
               end else m_st = 2;
            end
         2: if (valid) begin
               m_cnt++;
               if (occ < DEPTH) begin
                  e_push = 1'b1;
                  e_word = {2'b00, data};
               end else if (m_lost < 255) m_lost++;
               if (m_cnt == m_conf) begin
`ifdef ADC_FRAME_PACKER_TRAILER_EN
                  m_st = 3;
`else
                  m_st = 0; e_done = 1'b1;
`endif
               end
            end
         default: if (occ < DEPTH) begin
               e_push = 1'b1;
               e_word = {2'b11, 6'b0, 8'(m_lost)};
               e_done = 1'b1;
               m_st   = 0;
            end
      endcase
      chk("done", 32'(DONE), 32'(e_done));
      if (DONE) done_cnt++;
      if (FIFO_WRITE) begin
         got_q.push_back(FIFO_DATA);
         n_wr++;
      end
      if (e_pop) void'(exp_q.pop_front());
      if (e_push) exp_q.push_back(e_word);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Run one frame: ramp data from base during capture, random noise elsewhere
   task automatic frame(input int n, input logic [1:0] c, input int vprob, input int fprob,
                        input logic [13:0] base);
      int k = 0;
      int g = 0;
      conf  = 16'(n);
      ch    = c;
      start = 1'b1;
      valid = 1'b0;
      full  = ($urandom_range(99) < fprob);
      step();
      while (m_st != 0 && g < 2000) begin
         valid = ($urandom_range(99) < vprob);
         full  = ($urandom_range(99) < fprob);
         if (m_st == 2) begin
            data = base + 14'(k);
            if (valid) k++;
         end else data = 14'($urandom);
         step();
         g++;
      end
      chk("frame_end_busy", 32'(BUSY), 32'h0);
   endtask

   task automatic drain();
      int g = 0;
      full  = 1'b0;
      valid = 1'b0;
      while ((exp_q.size() > 0 || m_st != 0) && g < 500) begin
         step();
         g++;
      end
      chk("drain_fifo_write", 32'(FIFO_WRITE), 32'h0);
   endtask

   function automatic logic [31:0] got(input int i);
      logic [31:0] v = 'x;
      if (i >= 0 && i < got_q.size()) v = 32'(got_q[i]);
      return v;
   endfunction

   initial begin
      int d0;
      rst = 1'b1; data = '0; valid = 1'b0; start = 1'b0; conf = '0; ch = '0; full = 1'b0;
      done_cnt = 0; n_wr = 0;
      model_reset();
      #3;
      chk("rst_fifo_data", 32'(FIFO_DATA), 32'h0);
      chk("rst_fifo_write", 32'(FIFO_WRITE), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_lost", 32'(LOST_COUNT), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic 4-sample frame, ramp from 0x10
      got_q.delete(); done_cnt = 0;
      frame(4, 2'd2, 100, 0, 14'h10);
      drain();
      chk("f0_hdr", got(0), 32'hA000);
      chk("f0_d0", got(1), 32'h0010);
      chk("f0_d1", got(2), 32'h0011);
      chk("f0_d2", got(3), 32'h0012);
      chk("f0_d3", got(4), 32'h0013);
`ifdef ADC_FRAME_PACKER_TRAILER_EN
      chk("f0_trl", got(5), 32'hC000);
      chk("f0_len", 32'(got_q.size()), 32'd6);
`else
      chk("f0_len", 32'(got_q.size()), 32'd5);
`endif
      chk("f0_done_cnt", 32'(done_cnt), 32'd1);
      chk("f0_lost", 32'(LOST_COUNT), 32'd0);

      // Second frame header carries the next frame count
      got_q.delete();
      frame(4, 2'd2, 100, 0, 14'h20);
      drain();
      chk("f1_hdr", got(0), 32'hA001);

      // Empty frames up to the wrap point of the frame counter
      d0 = done_cnt;
      for (int i = 0; i < 4094; i++) frame(0, 2'd2, 50, 0, 14'h0);
      chk("empty_frames_done", 32'(done_cnt - d0), 32'd4094);
      drain();
      got_q.delete();
      frame(1, 2'd2, 100, 0, 14'h5);
      drain();
      chk("wrap_hdr", got(0), 32'hA000);

      // Back-pressure: 40 samples with the downstream FIFO full
      got_q.delete(); n_wr = 0; d0 = done_cnt;
      conf = 16'd40; ch = 2'd2; start = 1'b1; full = 1'b1; valid = 1'b1;
      step();
      for (int i = 0; i < 60 && m_st != 0 && m_st != 3; i++) begin
         data = 14'(i);
         step();
      end
      chk("ovf_lost", 32'(LOST_COUNT), 32'd25);
      chk("ovf_nothing_written", 32'(n_wr), 32'd0);
      drain();
`ifdef ADC_FRAME_PACKER_TRAILER_EN
      chk("ovf_drained", 32'(n_wr), 32'd17);
      chk("ovf_trl", got(16), 32'hC019);
`else
      chk("ovf_drained", 32'(n_wr), 32'd16);
`endif
      chk("ovf_done_cnt", 32'(done_cnt - d0), 32'd1);

      // START while busy is ignored
      got_q.delete();
      conf = 16'd6; ch = 2'd1; start = 1'b1; valid = 1'b0;
      step();
      valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data = 14'(100 + i);
         step();
      end
      conf = 16'd2; ch = 2'd3; start = 1'b1;
      for (int i = 0; i < 20 && m_st != 0; i++) begin
         data = 14'(200 + i);
         step();
      end
      drain();
      chk("busy_start_hdr_ch", got(0) >> 12, 32'h9);
`ifdef ADC_FRAME_PACKER_TRAILER_EN
      chk("busy_start_len", 32'(got_q.size()), 32'd8);
`else
      chk("busy_start_len", 32'(got_q.size()), 32'd7);
`endif

      // Reset in the middle of a lossy capture
      conf = 16'd30; ch = 2'd3; start = 1'b1; full = 1'b1; valid = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
         data = 14'($urandom);
         step();
      end
      full = 1'b0;
      step();
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_fifo_write", 32'(FIFO_WRITE), 32'h0);
      chk("mid_rst_busy", 32'(BUSY), 32'h0);
      chk("mid_rst_lost", 32'(LOST_COUNT), 32'h0);
      chk("mid_rst_fifo_data", 32'(FIFO_DATA), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      got_q.delete();
      frame(2, 2'd0, 100, 0, 14'h33);
      drain();
      chk("post_rst_hdr", got(0), 32'h8000);

      // Randomized frames
      for (int i = 0; i < 25; i++) begin
         frame($urandom_range(24), 2'($urandom), $urandom_range(100, 30), $urandom_range(60),
               14'($urandom));
      end
      drain();

      // Exactly three samples dropped
      got_q.delete();
      conf = 16'd18; ch = 2'd2; start = 1'b1; full = 1'b1; valid = 1'b1;
      step();
      for (int i = 0; i < 40 && m_st != 0 && m_st != 3; i++) begin
         data = 14'(i + 1);
         step();
      end
      chk("drop3_lost", 32'(LOST_COUNT), 32'd3);
      drain();
`ifdef ADC_FRAME_PACKER_TRAILER_EN
      chk("drop3_last", 32'(got_q[$]), 32'hC003);
      chk("drop3_len", 32'(got_q.size()), 32'd17);
`else
      chk("drop3_last_tag", 32'(got_q[$] >> 14), 32'h0);
      chk("drop3_len", 32'(got_q.size()), 32'd16);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
